// File: rtl/lfsr_prbs_gen.sv
// PRBS source: N-bit Fibonacci/Galois LFSR producing STEP bits per beat on a
// valid/ready stream, with seed loading, zero-state recovery and period measurement.
module lfsr_prbs_gen #(
   parameter int unsigned    N      = 8,
   parameter logic [N-1:0]   TAPS   = 8'hB8,
   parameter int unsigned    GALOIS = 0,
   parameter int unsigned    STEP   = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            load,
   input  logic [N-1:0]    seed_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [STEP-1:0] data_out,
   output logic            wrap,
   output logic            period_valid,
   output logic [N-1:0]    period_len,
   output logic            lock_err,
   output logic [N-1:0]    state
);

   localparam logic [N:0] CNT_MAX = '1;

   logic [N-1:0]    state_reg;
   logic [N-1:0]    seed_reg;
   logic [N-1:0]    period_len_reg;
   logic [N:0]      cnt_reg;
   logic [STEP-1:0] data_reg;
   logic            out_valid_reg;
   logic            wrap_reg;
   logic            lock_err_reg;
   logic            period_valid_reg;

   logic [N-1:0]    state_next;
   logic [STEP-1:0] bits_next;
   logic [N:0]      cnt_next;
   logic [N+1:0]    cnt_sum;
   logic [N:0]      hit_k;
   logic            hit;
   logic            adv;
   logic            zero_seed;

   function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
      if (GALOIS != 0)
         return (s << 1) ^ ({N{s[N-1]}} & TAPS);
      else
         return {s[N-2:0], ^(s & TAPS)};
   endfunction

   // Unrolled beat: walk STEP single steps, collecting output bits oldest-first
   // and noting the earliest intermediate state that returns to the seed.
   always_comb begin
      logic [N-1:0] s;
      s         = state_reg;
      bits_next = '0;
      hit       = 1'b0;
      hit_k     = '0;
      for (int j = 0; j < STEP; j++) begin
         bits_next[STEP-1-j] = s[N-1];
         s = lfsr_step(s);
         if (!hit && (s == seed_reg)) begin
            hit   = 1'b1;
            hit_k = (N+1)'(j + 1);
         end
      end
      state_next = s;
   end

   assign cnt_sum   = {1'b0, cnt_reg} + (N+2)'(STEP);
   assign cnt_next  = cnt_sum[N+1] ? CNT_MAX : cnt_sum[N:0];
   assign adv       = en & (~out_valid_reg | out_ready) & ~load;
   assign zero_seed = (seed_in == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= N'(1);
         seed_reg         <= N'(1);
         period_len_reg   <= '0;
         cnt_reg          <= '0;
         data_reg         <= '0;
         out_valid_reg    <= 1'b0;
         wrap_reg         <= 1'b0;
         lock_err_reg     <= 1'b0;
         period_valid_reg <= 1'b0;
      end else begin
         wrap_reg     <= 1'b0;
         lock_err_reg <= 1'b0;
         if (load) begin
            state_reg        <= zero_seed ? N'(1) : seed_in;
            seed_reg         <= zero_seed ? N'(1) : seed_in;
            lock_err_reg     <= zero_seed;
            out_valid_reg    <= 1'b0;
            cnt_reg          <= '0;
            period_valid_reg <= 1'b0;
         end else if (state_reg == '0) begin
            // An all-zero state never leaves itself; kick it back to 1.
            state_reg    <= N'(1);
            lock_err_reg <= 1'b1;
            if (out_valid_reg && out_ready)
               out_valid_reg <= 1'b0;
         end else if (adv) begin
            state_reg     <= state_next;
            data_reg      <= bits_next;
            out_valid_reg <= 1'b1;
            cnt_reg       <= cnt_next;
            if (hit) begin
               wrap_reg <= 1'b1;
               if (!period_valid_reg) begin
                  period_valid_reg <= 1'b1;
                  period_len_reg   <= N'(cnt_reg + hit_k);
               end
            end
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign state        = state_reg;
   assign data_out     = data_reg;
   assign out_valid    = out_valid_reg;
   assign wrap         = wrap_reg;
   assign lock_err     = lock_err_reg;
   assign period_valid = period_valid_reg;
   assign period_len   = period_len_reg;

endmodule
